test_monitor: RTL



---
 rtl/test_monitor_if.sv | 25 ++
 rtl/test_monitor.sv | 113 +++++++++++
 2 files changed

// File: rtl/test_monitor_if.sv
// Supervision bus between the test monitor and the benches it controls.
// The monitor is the master: it drives test_reset and the verdict outputs.
interface test_monitor_if #(
  parameter int unsigned NUM_TESTS = 4,
  parameter int unsigned CNT_W     = 32
);
  logic [NUM_TESTS-1:0] test_fail;
  logic [NUM_TESTS-1:0] test_finish;
  logic                 test_reset;
  logic                 done;
  logic                 pass;
  logic [NUM_TESTS-1:0] fail_mask;
  logic                 timeout;
  logic [CNT_W-1:0]     cycles;

  modport master (
    input  test_fail, test_finish,
    output test_reset, done, pass, fail_mask, timeout, cycles
  );

  modport slave (
    output test_fail, test_finish,
    input  test_reset, done, pass, fail_mask, timeout, cycles
  );
endinterface

// File: rtl/test_monitor.sv
// Test monitor: holds benches in reset for RST_CYCLES, then collects sticky
// finish/fail flags until every test finishes or TIMEOUT RUN cycles elapse,
// and freezes a registered verdict until the next reset.
module test_monitor #(
  parameter int unsigned NUM_TESTS  = 4,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input logic            clock,
  input logic            reset,
  test_monitor_if.master bus
);
  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {StInit, StRun, StDone} state_e;

  state_e               r_state, w_state_nxt;
  logic [RcW-1:0]       r_rst_cnt, w_rst_cnt_nxt;
  logic [NUM_TESTS-1:0] r_fin_mask, w_fin_mask_nxt;
  logic [NUM_TESTS-1:0] r_fail_mask, w_fail_mask_nxt;
  logic [CNT_W-1:0]     r_cycles, w_cycles_nxt;
  logic                 r_test_reset, w_test_reset_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_pass, w_pass_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic                 w_fin_all;
  logic                 w_timeout_hit;
  logic [CNT_W:0]       w_cyc_inc;

  // Extra MSB catches counter wrap so the count saturates and timeout still fires.
  assign w_cyc_inc     = {1'b0, r_cycles} + (CNT_W+1)'(1);
  assign w_fin_all     = &(r_fin_mask | bus.test_finish);
  assign w_timeout_hit = (w_cyc_inc >= (CNT_W+1)'(TIMEOUT));

  // Next-state and next-output logic for the INIT/RUN/DONE sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_rst_cnt_nxt    = r_rst_cnt;
    w_fin_mask_nxt   = r_fin_mask;
    w_fail_mask_nxt  = r_fail_mask;
    w_cycles_nxt     = r_cycles;
    w_test_reset_nxt = r_test_reset;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;
    w_timeout_nxt    = r_timeout;

    unique case (r_state)
      StInit: begin
        w_rst_cnt_nxt = r_rst_cnt + RcW'(1);
        if (r_rst_cnt == RcW'(RST_CYCLES - 1)) begin
          w_state_nxt      = StRun;
          w_test_reset_nxt = 1'b0;
        end
      end
      StRun: begin
        w_fin_mask_nxt  = r_fin_mask | bus.test_finish;
        w_fail_mask_nxt = r_fail_mask | bus.test_fail;
        w_cycles_nxt    = w_cyc_inc[CNT_W] ? r_cycles : w_cyc_inc[CNT_W-1:0];
        // Finish-all takes priority over a coincident timeout.
        if (w_fin_all) begin
          w_state_nxt   = StDone;
          w_done_nxt    = 1'b1;
          w_pass_nxt    = (w_fail_mask_nxt == '0);
          w_timeout_nxt = 1'b0;
        end else if (w_timeout_hit) begin
          w_state_nxt   = StDone;
          w_done_nxt    = 1'b1;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end
      end
      StDone: begin
      end
      default: begin
        w_state_nxt = StInit;
      end
    endcase
  end

  // State and output registers; reset restarts the whole sequence asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StInit;
      r_rst_cnt    <= '0;
      r_fin_mask   <= '0;
      r_fail_mask  <= '0;
      r_cycles     <= '0;
      r_test_reset <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_fin_mask   <= w_fin_mask_nxt;
      r_fail_mask  <= w_fail_mask_nxt;
      r_cycles     <= w_cycles_nxt;
      r_test_reset <= w_test_reset_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign bus.test_reset = r_test_reset;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.fail_mask  = r_fail_mask;
  assign bus.timeout    = r_timeout;
  assign bus.cycles     = r_cycles;
endmodule
